// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader_pkg
// Description : Shared state encoding and framing constants for imem_loader.
// Revision    : 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

    typedef logic [2:0] state_t;

    localparam state_t c_ST_IDLE   = 3'd0;
    localparam state_t c_ST_LEN_HI = 3'd1;
    localparam state_t c_ST_LEN_LO = 3'd2;
    localparam state_t c_ST_DATA   = 3'd3;
    localparam state_t c_ST_DONE   = 3'd4;
    localparam state_t c_ST_ERR    = 3'd5;

    localparam int c_HDR_BYTES      = 2;
    localparam int c_BYTES_PER_WORD = 4;

    // States in which a session is in flight and bytes may be accepted.
    function automatic logic is_busy(input state_t s);
        return (s == c_ST_LEN_HI) || (s == c_ST_LEN_LO) || (s == c_ST_DATA);
    endfunction

endpackage
`default_nettype wire

// File: rtl/imem_loader_byte_packer.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader_byte_packer
// Description : Shifts stream bytes into a big-endian word and flags the
//               cycle the final byte of a word is consumed.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader_byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clr,
    input  logic        i_shift,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_valid
);

    localparam int c_IDX_W = $clog2(c_BYTES_PER_WORD);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_BYTES_PER_WORD - 1);

    logic [23:0]         r_sh;
    logic [c_IDX_W-1:0]  r_idx;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_sh  <= '0;
            r_idx <= '0;
        end else if (i_shift) begin
            r_sh  <= {r_sh[15:0], i_byte};
            r_idx <= r_idx + c_IDX_W'(1);
        end
    end

    // The last byte is taken straight from the input so the word is complete
    // on the cycle it is consumed.
    assign o_word       = {r_sh, i_byte};
    assign o_word_valid = i_shift && (r_idx == c_LAST_IDX);

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Loads a length-prefixed byte stream into instruction memory as
//               big-endian words, then releases the CPU via start_o.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int MAX_WORDS = 256,
    parameter int CNT_WIDTH = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic [7:0]  byte_i,
    input  logic        byte_valid_i,
    output logic        byte_ready_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    output logic        busy_o,
    output logic        start_o,
    output logic        err_o
);

    localparam int c_WIDX = $clog2(MAX_WORDS) + 1;
    localparam logic [CNT_WIDTH-1:0] c_MAX_CNT = CNT_WIDTH'(MAX_WORDS);

    generate
        if (CNT_WIDTH != 8 * c_HDR_BYTES) begin : g_bad_cnt_width
            $error("imem_loader: CNT_WIDTH must equal the header byte width");
        end
    endgenerate

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_WIDTH-1:0] r_count;
    logic [CNT_WIDTH-1:0] w_len;
    logic [c_WIDX-1:0]    r_word_idx;
    logic                 r_ready;
    logic                 r_we;
    logic                 r_start;
    logic                 r_err;
    logic                 w_start_nxt;
    logic                 w_err_nxt;
    logic [31:0]          r_addr;
    logic [31:0]          r_data;
    logic [31:0]          w_pk_word;
    logic                 w_fire;
    logic                 w_shift;
    logic                 w_pk_clr;
    logic                 w_word_done;
    logic                 w_last_word;

    assign w_fire      = byte_valid_i && r_ready;
    assign w_len       = {r_count[CNT_WIDTH-1:8], byte_i};
    assign w_shift     = w_fire && (r_state == c_ST_DATA);
    assign w_pk_clr    = w_fire && (r_state == c_ST_LEN_LO);
    assign w_last_word = (CNT_WIDTH'(r_word_idx) + CNT_WIDTH'(1)) == r_count;

    imem_loader_byte_packer u_packer (
        .clk          (clk_i),
        .rst          (rst_i),
        .i_clr        (w_pk_clr),
        .i_shift      (w_shift),
        .i_byte       (byte_i),
        .o_word       (w_pk_word),
        .o_word_valid (w_word_done)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_start_nxt = r_start;
        w_err_nxt   = r_err;
        case (r_state)
            c_ST_IDLE: begin
                if (load_i) begin
                    w_state_nxt = c_ST_LEN_HI;
                    w_start_nxt = 1'b0;
                    w_err_nxt   = 1'b0;
                end
            end
            c_ST_LEN_HI: begin
                if (w_fire) w_state_nxt = c_ST_LEN_LO;
            end
            c_ST_LEN_LO: begin
                if (w_fire) begin
                    if (w_len == '0)             w_state_nxt = c_ST_DONE;
                    else if (w_len > c_MAX_CNT)  w_state_nxt = c_ST_ERR;
                    else                         w_state_nxt = c_ST_DATA;
                end
            end
            c_ST_DATA: begin
                // Leaving on the final word makes start_o rise right after its strobe.
                if (w_word_done && w_last_word) w_state_nxt = c_ST_DONE;
            end
            c_ST_DONE: begin
                if (load_i) begin
                    w_state_nxt = c_ST_LEN_HI;
                    w_start_nxt = 1'b0;
                end else begin
                    w_start_nxt = 1'b1;
                end
            end
            c_ST_ERR: begin
                if (load_i) begin
                    w_state_nxt = c_ST_LEN_HI;
                    w_err_nxt   = 1'b0;
                end else begin
                    w_err_nxt   = 1'b1;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= c_ST_IDLE;
            r_count    <= '0;
            r_word_idx <= '0;
            r_ready    <= 1'b0;
            r_we       <= 1'b0;
            r_start    <= 1'b0;
            r_err      <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_start <= w_start_nxt;
            r_err   <= w_err_nxt;
            // Ready drops for the strobe cycle, giving the 4-bytes-per-5-cycles rate.
            r_ready <= is_busy(w_state_nxt) && !w_word_done;
            r_we    <= w_word_done;
            if (w_fire && (r_state == c_ST_LEN_HI)) begin
                r_count <= CNT_WIDTH'({byte_i, 8'h00});
            end
            if (w_fire && (r_state == c_ST_LEN_LO)) begin
                r_count    <= w_len;
                r_word_idx <= '0;
            end
            if (w_word_done) begin
                r_addr     <= {{(32 - c_WIDX - 2){1'b0}}, r_word_idx, 2'b00};
                r_data     <= w_pk_word;
                r_word_idx <= r_word_idx + c_WIDX'(1);
            end
        end
    end

    assign byte_ready_o = r_ready;
    assign mem_we_o     = r_we;
    assign mem_addr_o   = r_addr;
    assign mem_data_o   = r_data;
    assign busy_o       = is_busy(r_state);
    assign start_o      = r_start;
    assign err_o        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_loader
// Description : Directed, table-driven self-checking bench for imem_loader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    typedef struct {
        logic [15:0] len;
        logic [31:0] seed;
        int          nsend;
        logic        exp_err;
        logic        exp_start;
        int          exp_wr;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        load_i;
    logic [7:0]  byte_i;
    logic        byte_valid_i;
    logic        byte_ready_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic        busy_o;
    logic        start_o;
    logic        err_o;

    int checks   = 0;
    int failures = 0;
    int cons_cnt = 0;
    int bp_viol  = 0;

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    logic [7:0]  basic_bytes [10];
    logic        vpat [4];
    vec_t        tbl [6];

    imem_loader #(.MAX_WORDS(256), .CNT_WIDTH(16)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .load_i       (load_i),
        .byte_i       (byte_i),
        .byte_valid_i (byte_valid_i),
        .byte_ready_o (byte_ready_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .busy_o       (busy_o),
        .start_o      (start_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we_o) begin
            wr_addr.push_back(mem_addr_o);
            wr_data.push_back(mem_data_o);
            if (byte_ready_o) bp_viol++;
        end
        if (byte_valid_i && byte_ready_o) cons_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic pulse_load();
        load_i = 1'b1;
        tick();
        load_i = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        byte_i       = b;
        byte_valid_i = 1'b1;
        while (!byte_ready_o && n < 50) begin
            tick();
            n++;
        end
        check("send_ready", {31'd0, byte_ready_o}, 32'd1);
        if (byte_ready_o) tick();
    endtask

    task automatic wait_flag(input int budget);
        int n = 0;
        while (!(start_o || err_o) && n < budget) begin
            tick();
            n++;
        end
        check("flag_wait", {31'd0, start_o || err_o}, 32'd1);
    endtask

    task automatic run_session(input logic [15:0] len, input logic [31:0] seed, input int nsend);
        logic [31:0] w;
        wr_addr.delete();
        wr_data.delete();
        pulse_load();
        send_byte(len[15:8]);
        send_byte(len[7:0]);
        for (int k = 0; k < nsend; k++) begin
            w = seed + k * 32'h01010101;
            for (int b = 3; b >= 0; b--) send_byte(w[b*8 +: 8]);
        end
        byte_valid_i = 1'b0;
        wait_flag(40);
    endtask

    task automatic check_writes(input string tag, input int n, input logic [31:0] seed);
        check({tag, "_nwr"}, wr_addr.size(), n);
        for (int k = 0; k < n && k < wr_addr.size(); k++) begin
            check({tag, "_addr"}, wr_addr[k], k * 4);
            check({tag, "_data"}, wr_data[k], seed + k * 32'h01010101);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        basic_bytes = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h0A};
        vpat        = '{1'b1, 1'b0, 1'b0, 1'b1};
        tbl[0] = '{16'd1,      32'hDEADBEEF, 1,   1'b0, 1'b1, 1};
        tbl[1] = '{16'd3,      32'h10203040, 3,   1'b0, 1'b1, 3};
        tbl[2] = '{16'd0,      32'h00000000, 0,   1'b0, 1'b1, 0};
        tbl[3] = '{16'd257,    32'h00000000, 0,   1'b1, 1'b0, 0};
        tbl[4] = '{16'hFFFF,   32'h00000000, 0,   1'b1, 1'b0, 0};
        tbl[5] = '{16'd256,    32'hC0000000, 256, 1'b0, 1'b1, 256};

        rst_i = 1'b1; load_i = 1'b0; byte_i = 8'h00; byte_valid_i = 1'b0;
        tick(); tick();
        check("rst_we",    {31'd0, mem_we_o}, 0);
        check("rst_addr",  mem_addr_o, 0);
        check("rst_data",  mem_data_o, 0);
        check("rst_ready", {31'd0, byte_ready_o}, 0);
        check("rst_busy",  {31'd0, busy_o}, 0);
        check("rst_start", {31'd0, start_o}, 0);
        check("rst_err",   {31'd0, err_o}, 0);
        rst_i = 1'b0;
        byte_valid_i = 1'b1;
        tick();
        check("idle_no_consume", cons_cnt, 0);
        byte_valid_i = 1'b0;

        // Basic load with continuous valid.
        wr_addr.delete(); wr_data.delete();
        pulse_load();
        check("basic_busy",  {31'd0, busy_o}, 1);
        check("basic_ready", {31'd0, byte_ready_o}, 1);
        for (int i = 0; i < 10; i++) send_byte(basic_bytes[i]);
        byte_valid_i = 1'b0;
        check("basic_we2",   {31'd0, mem_we_o}, 1);
        check("basic_addr2", mem_addr_o, 32'h4);
        check("basic_data2", mem_data_o, 32'h2009000A);
        tick();
        check("basic_start", {31'd0, start_o}, 1);
        check("basic_busy0", {31'd0, busy_o}, 0);
        check("basic_we0",   {31'd0, mem_we_o}, 0);
        check("basic_nwr",   wr_addr.size(), 2);
        if (wr_addr.size() >= 2) begin
            check("basic_a0", wr_addr[0], 32'h0);
            check("basic_d0", wr_data[0], 32'h20080005);
            check("basic_a1", wr_addr[1], 32'h4);
            check("basic_d1", wr_data[1], 32'h2009000A);
        end

        // Backpressure: valid pattern 1,0,0,1 repeating.
        wr_addr.delete(); wr_data.delete();
        pulse_load();
        cons_cnt = 0; bp_viol = 0; idx = 0;
        for (int cyc = 0; cyc < 200 && idx < 10; cyc++) begin
            byte_valid_i = vpat[cyc % 4];
            byte_i       = basic_bytes[idx];
            if (byte_valid_i && byte_ready_o) idx++;
            tick();
        end
        byte_valid_i = 1'b0;
        wait_flag(20);
        check("bp_consumed", cons_cnt, 10);
        check("bp_viol",     bp_viol, 0);
        check("bp_nwr",      wr_addr.size(), 2);
        if (wr_addr.size() >= 2) begin
            check("bp_a0", wr_addr[0], 32'h0);
            check("bp_d0", wr_data[0], 32'h20080005);
            check("bp_a1", wr_addr[1], 32'h4);
            check("bp_d1", wr_data[1], 32'h2009000A);
        end

        // Zero length: start_o two cycles after the last header byte.
        wr_addr.delete(); wr_data.delete();
        pulse_load();
        send_byte(8'h00);
        send_byte(8'h00);
        byte_valid_i = 1'b0;
        check("zl_start_c1", {31'd0, start_o}, 0);
        tick();
        check("zl_start_c2", {31'd0, start_o}, 1);
        check("zl_nwr",      wr_addr.size(), 0);

        // Illegal length, then recovery.
        wr_addr.delete(); wr_data.delete();
        pulse_load();
        send_byte(8'h01);
        send_byte(8'h01);
        byte_valid_i = 1'b0;
        wait_flag(10);
        check("ill_err",   {31'd0, err_o}, 1);
        check("ill_start", {31'd0, start_o}, 0);
        tick(); tick();
        check("ill_nwr",   wr_addr.size(), 0);
        pulse_load();
        check("ill_err_clr", {31'd0, err_o}, 0);
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
        byte_valid_i = 1'b0;
        wait_flag(10);
        check("rec_start", {31'd0, start_o}, 1);
        check("rec_nwr",   wr_addr.size(), 1);
        if (wr_addr.size() >= 1) begin
            check("rec_addr", wr_addr[0], 32'h0);
            check("rec_data", wr_data[0], 32'hAABBCCDD);
        end

        // Reset in the middle of word 1.
        wr_addr.delete(); wr_data.delete();
        pulse_load();
        for (int i = 0; i < 8; i++) send_byte(basic_bytes[i]);
        byte_valid_i = 1'b0;
        rst_i = 1'b1;
        tick();
        check("mrst_we",    {31'd0, mem_we_o}, 0);
        check("mrst_addr",  mem_addr_o, 0);
        check("mrst_data",  mem_data_o, 0);
        check("mrst_ready", {31'd0, byte_ready_o}, 0);
        check("mrst_busy",  {31'd0, busy_o}, 0);
        check("mrst_start", {31'd0, start_o}, 0);
        rst_i = 1'b0;
        tick(); tick();
        check("mrst_nwr", wr_addr.size(), 1);
        run_session(16'd1, 32'h55AA55AA, 1);
        check_writes("mrst_new", 1, 32'h55AA55AA);

        // Ignored load during DATA, then a reload after DONE.
        wr_addr.delete(); wr_data.delete();
        pulse_load();
        for (int i = 0; i < 10; i++) begin
            if (i == 5) load_i = 1'b1;
            send_byte(basic_bytes[i]);
            load_i = 1'b0;
            if (i == 5) check("ign_busy", {31'd0, busy_o}, 1);
        end
        byte_valid_i = 1'b0;
        wait_flag(10);
        check("ign_nwr", wr_addr.size(), 2);
        if (wr_addr.size() >= 2) begin
            check("ign_d0", wr_data[0], 32'h20080005);
            check("ign_d1", wr_data[1], 32'h2009000A);
        end
        check("ign_start_pre", {31'd0, start_o}, 1);
        run_session(16'd1, 32'hCAFEF00D, 1);
        check_writes("reload", 1, 32'hCAFEF00D);

        // Table-driven sessions.
        for (int t = 0; t < 6; t++) begin
            run_session(tbl[t].len, tbl[t].seed, tbl[t].nsend);
            tick(); tick();
            check($sformatf("tbl%0d_err", t),   {31'd0, err_o},   {31'd0, tbl[t].exp_err});
            check($sformatf("tbl%0d_start", t), {31'd0, start_o}, {31'd0, tbl[t].exp_start});
            check_writes($sformatf("tbl%0d", t), tbl[t].exp_wr, tbl[t].seed);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
